npu_setreset_pulse_sched: RTL and testbench

Sequencer that drives SET/RESET/READMEM operations on the NPU v2 array from the wrap config registers.
- Walks WL addresses from cfg_wl_st to cfg_wl_end.
- At each point, repeats a programmable list of up to 4 ops cfg_pt_loop times.
- For SET/RESET ops, times the WL/SEL/BL switch windows inside a pulse.
- For READMEM ops, hands off to the external read/ADC engine.
- Sits between the AXI config/trigger registers and the pad-level switch drivers (DACWL_SW/DACSEL_SW/DACBL_SW, SET, RESET).

---
 rtl/npu_setreset_pulse_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_npu_setreset_pulse_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_setreset_pulse_sched.sv
// SET/RESET/READMEM sequencer for the NPU v2 array: walks WL points, repeats an op list per point,
// and times the WL/SEL/BL switch windows inside each SET or RESET pulse.
module npu_setreset_pulse_sched #(
  parameter int CNT_W  = 16,
  parameter int WL_W   = 8,
  parameter int LOOP_W = 16,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WL_W-1:0]   cfg_wl_st,
  input  logic [WL_W-1:0]   cfg_wl_end,
  input  logic [7:0]        cfg_op_seq,
  input  logic [2:0]        cfg_op_num,
  input  logic [LOOP_W-1:0] cfg_pt_loop,
  input  logic [CNT_W-1:0]  cfg_set_width,
  input  logic [CNT_W-1:0]  cfg_reset_width,
  input  logic [CNT_W-1:0]  cfg_set_wl_st,
  input  logic [CNT_W-1:0]  cfg_set_wl_end,
  input  logic [CNT_W-1:0]  cfg_set_sel_st,
  input  logic [CNT_W-1:0]  cfg_set_sel_end,
  input  logic [CNT_W-1:0]  cfg_set_bl_st,
  input  logic [CNT_W-1:0]  cfg_set_bl_end,
  input  logic [CNT_W-1:0]  cfg_reset_wl_st,
  input  logic [CNT_W-1:0]  cfg_reset_wl_end,
  input  logic [CNT_W-1:0]  cfg_reset_sel_st,
  input  logic [CNT_W-1:0]  cfg_reset_sel_end,
  input  logic [CNT_W-1:0]  cfg_reset_bl_st,
  input  logic [CNT_W-1:0]  cfg_reset_bl_end,
  input  logic              read_done,
  output logic              read_req,
  output logic [WL_W-1:0]   wl_addr,
  output logic              wl_en,
  output logic              sel_en,
  output logic              bl_en,
  output logic              set_mode,
  output logic              reset_mode,
  output logic              busy,
  output logic              done,
  output logic              stopped,
  output logic              cfg_err,
  output logic [STAT_W-1:0] pulse_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PULSE, S_READ, S_NEXT_OP, S_DONE} state_t;

  state_t                  r_state;
  logic                    r_load_ph;
  logic [WL_W-1:0]         r_wl_st;
  logic [WL_W-1:0]         r_wl_end;
  logic [7:0]              r_op_seq;
  logic [2:0]              r_op_num;
  logic [LOOP_W-1:0]       r_pt_loop;
  logic [CNT_W-1:0]        r_set_w;
  logic [CNT_W-1:0]        r_rst_w;
  logic [5:0][CNT_W-1:0]   r_set_win;
  logic [5:0][CNT_W-1:0]   r_rst_win;
  logic [1:0]              r_op_idx;
  logic [LOOP_W-1:0]       r_loop_idx;
  logic [CNT_W-1:0]        r_k;
  logic                    r_cur_set;

  logic                    w_last_op;
  logic                    w_last_loop;
  logic                    w_run_done;
  logic [1:0]              w_disp_idx;
  logic [1:0]              w_disp_op;
  logic                    w_disp_set;
  logic [CNT_W-1:0]        w_disp_w;
  logic [5:0][CNT_W-1:0]   w_disp_win;
  state_t                  w_disp_state;
  logic                    w_dispatch;
  logic [CNT_W-1:0]        w_act_w;
  logic [5:0][CNT_W-1:0]   w_act_win;
  logic                    w_k_last;

  // Window layout {bl_end, bl_st, sel_end, sel_st, wl_end, wl_st}; k never exceeds width-1, so the
  // end bound is clipped implicitly and a window starting at or beyond the width never opens.
  function automatic logic [2:0] f_win(input logic [5:0][CNT_W-1:0] win, input logic [CNT_W-1:0] k);
    logic [2:0] en;
    en[0] = (k >= win[0]) && (k <= win[1]);
    en[1] = (k >= win[2]) && (k <= win[3]);
    en[2] = (k >= win[4]) && (k <= win[5]);
    return en;
  endfunction

  // Next-op selection and dispatch decode shared by LOAD and NEXT_OP.
  always_comb begin
    w_last_op   = ({1'b0, r_op_idx} == (r_op_num - 3'd1));
    w_last_loop = (r_loop_idx == (r_pt_loop - LOOP_W'(1)));
    w_run_done  = w_last_op && w_last_loop && (wl_addr == r_wl_end);
    w_disp_idx  = (r_state == S_LOAD) ? 2'd0 : (w_last_op ? 2'd0 : (r_op_idx + 2'd1));
    case (w_disp_idx)
      2'd0:    w_disp_op = r_op_seq[1:0];
      2'd1:    w_disp_op = r_op_seq[3:2];
      2'd2:    w_disp_op = r_op_seq[5:4];
      2'd3:    w_disp_op = r_op_seq[7:6];
      default: w_disp_op = r_op_seq[1:0];
    endcase
    w_disp_set = (w_disp_op == 2'd0);
    w_disp_w   = w_disp_set ? r_set_w : r_rst_w;
    w_disp_win = w_disp_set ? r_set_win : r_rst_win;
    case (w_disp_op)
      2'd0, 2'd1: w_disp_state = (w_disp_w != {CNT_W{1'b0}}) ? S_PULSE : S_NEXT_OP;
      2'd2:       w_disp_state = S_READ;
      default:    w_disp_state = S_NEXT_OP;
    endcase
    w_dispatch = ((r_state == S_LOAD) && r_load_ph && !(r_wl_end < r_wl_st)) ||
                 ((r_state == S_NEXT_OP) && !w_run_done);
    w_act_w    = r_cur_set ? r_set_w : r_rst_w;
    w_act_win  = r_cur_set ? r_set_win : r_rst_win;
    w_k_last   = (r_k == (w_act_w - CNT_W'(1)));
  end

  // Sequencer state machine; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_load_ph  <= 1'b0;
      r_wl_st    <= {WL_W{1'b0}};
      r_wl_end   <= {WL_W{1'b0}};
      r_op_seq   <= 8'd0;
      r_op_num   <= 3'd1;
      r_pt_loop  <= LOOP_W'(1);
      r_set_w    <= {CNT_W{1'b0}};
      r_rst_w    <= {CNT_W{1'b0}};
      r_set_win  <= {(6*CNT_W){1'b0}};
      r_rst_win  <= {(6*CNT_W){1'b0}};
      r_op_idx   <= 2'd0;
      r_loop_idx <= {LOOP_W{1'b0}};
      r_k        <= {CNT_W{1'b0}};
      r_cur_set  <= 1'b0;
      read_req   <= 1'b0;
      wl_addr    <= {WL_W{1'b0}};
      wl_en      <= 1'b0;
      sel_en     <= 1'b0;
      bl_en      <= 1'b0;
      set_mode   <= 1'b0;
      reset_mode <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stopped    <= 1'b0;
      cfg_err    <= 1'b0;
      pulse_cnt  <= {STAT_W{1'b0}};
    end else if (stop && (r_state != S_IDLE)) begin
      r_state    <= S_IDLE;
      r_load_ph  <= 1'b0;
      read_req   <= 1'b0;
      wl_en      <= 1'b0;
      sel_en     <= 1'b0;
      bl_en      <= 1'b0;
      set_mode   <= 1'b0;
      reset_mode <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      stopped    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state   <= S_LOAD;
            r_load_ph <= 1'b0;
            busy      <= 1'b1;
            stopped   <= 1'b0;
            cfg_err   <= 1'b0;
            pulse_cnt <= {STAT_W{1'b0}};
          end
        end
        S_LOAD: begin
          if (!r_load_ph) begin
            r_load_ph <= 1'b1;
            r_wl_st   <= cfg_wl_st;
            r_wl_end  <= cfg_wl_end;
            r_op_seq  <= cfg_op_seq;
            r_op_num  <= (cfg_op_num == 3'd0) ? 3'd1 : ((cfg_op_num > 3'd4) ? 3'd4 : cfg_op_num);
            r_pt_loop <= (cfg_pt_loop == {LOOP_W{1'b0}}) ? LOOP_W'(1) : cfg_pt_loop;
            r_set_w   <= cfg_set_width;
            r_rst_w   <= cfg_reset_width;
            r_set_win <= {cfg_set_bl_end, cfg_set_bl_st, cfg_set_sel_end, cfg_set_sel_st,
                          cfg_set_wl_end, cfg_set_wl_st};
            r_rst_win <= {cfg_reset_bl_end, cfg_reset_bl_st, cfg_reset_sel_end, cfg_reset_sel_st,
                          cfg_reset_wl_end, cfg_reset_wl_st};
          end else begin
            r_load_ph <= 1'b0;
            if (r_wl_end < r_wl_st) begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              wl_addr    <= r_wl_st;
              r_op_idx   <= 2'd0;
              r_loop_idx <= {LOOP_W{1'b0}};
            end
          end
        end
        S_PULSE: begin
          if (w_k_last) begin
            r_state    <= S_NEXT_OP;
            wl_en      <= 1'b0;
            sel_en     <= 1'b0;
            bl_en      <= 1'b0;
            set_mode   <= 1'b0;
            reset_mode <= 1'b0;
            pulse_cnt  <= pulse_cnt + STAT_W'(1);
          end else begin
            r_k                    <= r_k + CNT_W'(1);
            {bl_en, sel_en, wl_en} <= f_win(w_act_win, r_k + CNT_W'(1));
          end
        end
        S_READ: begin
          if (read_done) begin
            read_req <= 1'b0;
            r_state  <= S_NEXT_OP;
          end
        end
        S_NEXT_OP: begin
          if (w_run_done) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_last_op) begin
            r_op_idx <= r_op_idx + 2'd1;
          end else begin
            r_op_idx <= 2'd0;
            if (!w_last_loop) begin
              r_loop_idx <= r_loop_idx + LOOP_W'(1);
            end else begin
              r_loop_idx <= {LOOP_W{1'b0}};
              wl_addr    <= wl_addr + WL_W'(1);
            end
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Dispatch overrides the state chosen above when a new op is entered.
      if (w_dispatch) begin
        r_state   <= w_disp_state;
        r_cur_set <= w_disp_set;
        r_k       <= {CNT_W{1'b0}};
        case (w_disp_state)
          S_PULSE: begin
            set_mode               <= w_disp_set;
            reset_mode             <= !w_disp_set;
            {bl_en, sel_en, wl_en} <= f_win(w_disp_win, {CNT_W{1'b0}});
          end
          S_READ:  read_req <= 1'b1;
          default: read_req <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_setreset_pulse_sched.sv
// Table-driven bench for npu_setreset_pulse_sched with a done-triggered scoreboard and
// hand-written sequences for stop, start/stop collision and mid-run reset.
module tb_npu_setreset_pulse_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, stop, read_done;
  logic [7:0] cfg_wl_st, cfg_wl_end, cfg_op_seq;
  logic [2:0] cfg_op_num;
  logic [15:0] cfg_pt_loop, cfg_set_width, cfg_reset_width;
  logic [15:0] s_wl_st, s_wl_end, s_sel_st, s_sel_end, s_bl_st, s_bl_end;
  logic [15:0] r_wl_st, r_wl_end, r_sel_st, r_sel_end, r_bl_st, r_bl_end;
  logic read_req, wl_en, sel_en, bl_en, set_mode, reset_mode, busy, done, stopped, cfg_err;
  logic [7:0] wl_addr;
  logic [31:0] pulse_cnt;

  npu_setreset_pulse_sched #(.CNT_W(16), .WL_W(8), .LOOP_W(16), .STAT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_wl_st(cfg_wl_st), .cfg_wl_end(cfg_wl_end), .cfg_op_seq(cfg_op_seq),
    .cfg_op_num(cfg_op_num), .cfg_pt_loop(cfg_pt_loop),
    .cfg_set_width(cfg_set_width), .cfg_reset_width(cfg_reset_width),
    .cfg_set_wl_st(s_wl_st), .cfg_set_wl_end(s_wl_end), .cfg_set_sel_st(s_sel_st),
    .cfg_set_sel_end(s_sel_end), .cfg_set_bl_st(s_bl_st), .cfg_set_bl_end(s_bl_end),
    .cfg_reset_wl_st(r_wl_st), .cfg_reset_wl_end(r_wl_end), .cfg_reset_sel_st(r_sel_st),
    .cfg_reset_sel_end(r_sel_end), .cfg_reset_bl_st(r_bl_st), .cfg_reset_bl_end(r_bl_end),
    .read_done(read_done), .read_req(read_req), .wl_addr(wl_addr),
    .wl_en(wl_en), .sel_en(sel_en), .bl_en(bl_en), .set_mode(set_mode), .reset_mode(reset_mode),
    .busy(busy), .done(done), .stopped(stopped), .cfg_err(cfg_err), .pulse_cnt(pulse_cnt)
  );

  typedef struct {
    string       name;
    logic [7:0]  wl_st, wl_end, op_seq;
    logic [2:0]  op_num;
    logic [15:0] pt_loop, set_w, rst_w;
    logic [95:0] set_win, rst_win;   // {bl_end, bl_st, sel_end, sel_st, wl_end, wl_st}
    bit          disturb;
    int          e_pulses, e_set_rise, e_rst_rise, e_wl, e_sel, e_bl;
    int          e_wl_k, e_sel_k, e_bl_k, e_reads, e_first_pt;
    bit          e_err, chk_wl;
    int          e_wl_addr;
  } vec_t;

  localparam logic [95:0] SW1 = {16'd14, 16'd5, 16'd16, 16'd3, 16'd18, 16'd1};
  localparam logic [95:0] RW1 = {16'd50, 16'd40, 16'd100, 16'd2, 16'd38, 16'd0};
  localparam logic [95:0] SW4 = {16'd6, 16'd5, 16'd1, 16'd1, 16'd2, 16'd0};
  localparam logic [95:0] SW5 = {16'd0, 16'd0, 16'd2, 16'd4, 16'd4, 16'd0};

  vec_t vecs[7];
  vec_t sb_q[$];
  int n_tests = 0, n_fail = 0;

  int m_set_rise, m_rst_rise, m_wl, m_sel, m_bl, m_wl_k, m_sel_k, m_bl_k;
  int m_reads, m_first, m_done, m_viol, m_completed, m_busy, m_k;
  bit p_mode = 1'b0, p_set = 1'b0, p_rr = 1'b0;
  int g_set_w, g_rst_w;
  logic [7:0] g_first_wl;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    m_set_rise = 0; m_rst_rise = 0; m_wl = 0; m_sel = 0; m_bl = 0;
    m_wl_k = 0; m_sel_k = 0; m_bl_k = 0; m_reads = 0; m_first = 0;
    m_done = 0; m_viol = 0; m_completed = 0; m_busy = 0; m_k = 0;
  endtask

  task automatic sample();
    bit mode;
    mode = set_mode | reset_mode;
    if (mode) begin
      if (!p_mode) begin
        m_k = 0;
        if (set_mode) m_set_rise++;
        else m_rst_rise++;
        if (wl_addr == g_first_wl) m_first++;
      end else begin
        m_k++;
      end
      if (wl_en)  begin m_wl++;  m_wl_k  += m_k; end
      if (sel_en) begin m_sel++; m_sel_k += m_k; end
      if (bl_en)  begin m_bl++;  m_bl_k  += m_k; end
    end else if (p_mode) begin
      if (m_k + 1 == (p_set ? g_set_w : g_rst_w)) m_completed++;
    end
    if ((wl_en | sel_en | bl_en) && !mode) m_viol++;
    if (set_mode && reset_mode) m_viol++;
    if (read_req && !p_rr) m_reads++;
    if (done) m_done++;
    if (busy) m_busy++;
    p_mode = mode; p_set = set_mode; p_rr = read_req;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic apply_cfg(input vec_t v);
    cfg_wl_st = v.wl_st; cfg_wl_end = v.wl_end; cfg_op_seq = v.op_seq;
    cfg_op_num = v.op_num; cfg_pt_loop = v.pt_loop;
    cfg_set_width = v.set_w; cfg_reset_width = v.rst_w;
    {s_bl_end, s_bl_st, s_sel_end, s_sel_st, s_wl_end, s_wl_st} = v.set_win;
    {r_bl_end, r_bl_st, r_sel_end, r_sel_st, r_wl_end, r_wl_st} = v.rst_win;
    g_set_w = int'(v.set_w); g_rst_w = int'(v.rst_w); g_first_wl = v.wl_st;
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, ".wl_en"}, wl_en, 0);           chk({p, ".sel_en"}, sel_en, 0);
    chk({p, ".bl_en"}, bl_en, 0);           chk({p, ".set_mode"}, set_mode, 0);
    chk({p, ".reset_mode"}, reset_mode, 0); chk({p, ".read_req"}, read_req, 0);
    chk({p, ".busy"}, busy, 0);             chk({p, ".done"}, done, 0);
    chk({p, ".stopped"}, stopped, 0);       chk({p, ".cfg_err"}, cfg_err, 0);
    chk({p, ".wl_addr"}, wl_addr, 0);       chk({p, ".pulse_cnt"}, pulse_cnt, 0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    apply_cfg(v);
    clear_mon();
    sb_q.push_back(v);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 8000 && m_done == 0; c++) begin
      if (v.disturb && c == 5) begin
        cfg_op_seq = 8'hFF; cfg_set_width = 16'd3; cfg_wl_end = 8'd9; cfg_pt_loop = 16'd4;
        s_wl_st = 16'd0; s_wl_end = 16'd0;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    tick();
    e = sb_q.pop_front();
    chk({e.name, ".done_cnt"}, m_done, 1);
    chk({e.name, ".busy_after"}, busy, 0);
    chk({e.name, ".stopped"}, stopped, 0);
    chk({e.name, ".cfg_err"}, cfg_err, e.e_err);
    chk({e.name, ".pulse_cnt"}, pulse_cnt, e.e_pulses);
    chk({e.name, ".completed"}, m_completed, e.e_pulses);
    chk({e.name, ".set_pulses"}, m_set_rise, e.e_set_rise);
    chk({e.name, ".reset_pulses"}, m_rst_rise, e.e_rst_rise);
    chk({e.name, ".wl_cycles"}, m_wl, e.e_wl);
    chk({e.name, ".sel_cycles"}, m_sel, e.e_sel);
    chk({e.name, ".bl_cycles"}, m_bl, e.e_bl);
    chk({e.name, ".wl_ksum"}, m_wl_k, e.e_wl_k);
    chk({e.name, ".sel_ksum"}, m_sel_k, e.e_sel_k);
    chk({e.name, ".bl_ksum"}, m_bl_k, e.e_bl_k);
    chk({e.name, ".read_handshakes"}, m_reads, e.e_reads);
    chk({e.name, ".first_point_pulses"}, m_first, e.e_first_pt);
    chk({e.name, ".enable_violations"}, m_viol, 0);
    if (e.chk_wl) chk({e.name, ".wl_addr"}, wl_addr, e.e_wl_addr);
  endtask

  // Read engine model: answers each read_req rise with a one-cycle read_done 3 cycles later.
  initial begin
    bit rp;
    rp = 1'b0;
    read_done = 1'b0;
    forever begin
      @(negedge clk);
      if (read_req && !rp) begin
        repeat (3) @(negedge clk);
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
      end
      rp = read_req;
    end
  end

  initial begin
    bit reached;
    vecs[0] = '{"set_only", 8'd0, 8'd0, 8'h00, 3'd1, 16'd1, 16'd19, 16'd39, SW1, RW1, 1'b0,
                1, 1, 0, 18, 14, 10, 171, 133, 95, 0, 1, 1'b0, 1'b1, 0};
    vecs[1] = '{"rst_set_rd_rst", 8'd0, 8'd1, 8'h61, 3'd4, 16'd5, 16'd19, 16'd39, SW1, RW1, 1'b0,
                30, 10, 20, 960, 880, 100, 16530, 16130, 950, 10, 15, 1'b0, 1'b1, 1};
    vecs[2] = '{"cfg_err", 8'd5, 8'd2, 8'h00, 3'd1, 16'd1, 16'd19, 16'd39, SW1, RW1, 1'b0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0};
    vecs[3] = '{"zero_width", 8'd0, 8'd0, 8'h0C, 3'd2, 16'd1, 16'd0, 16'd39, SW1, RW1, 1'b0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 0};
    vecs[4] = '{"wl_top_nowrap", 8'd250, 8'd255, 8'h00, 3'd0, 16'd0, 16'd3, 16'd39, SW4, RW1, 1'b0,
                6, 6, 0, 18, 6, 0, 18, 6, 0, 0, 1, 1'b0, 1'b1, 255};
    vecs[5] = '{"op_num_clip", 8'd3, 8'd3, 8'h3F, 3'd7, 16'd2, 16'd5, 16'd39, SW5, RW1, 1'b0,
                2, 2, 0, 10, 0, 2, 20, 0, 0, 0, 2, 1'b0, 1'b1, 3};
    vecs[6] = vecs[0];
    vecs[6].name = "busy_start_cfg_change";
    vecs[6].disturb = 1'b1;

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    apply_cfg(vecs[0]);
    clear_mon();
    repeat (3) tick();
    chk_all_zero("reset_state");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort in the middle of a RESET pulse, then restart cleanly.
    apply_cfg(vecs[1]);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 5000 && !reached; c++) begin
      tick();
      if (m_completed >= 4 && reset_mode && m_k == 10) reached = 1'b1;
    end
    chk("stop.reached_pulse", reached, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop.wl_en", wl_en, 0);         chk("stop.sel_en", sel_en, 0);
    chk("stop.bl_en", bl_en, 0);         chk("stop.reset_mode", reset_mode, 0);
    chk("stop.set_mode", set_mode, 0);   chk("stop.read_req", read_req, 0);
    chk("stop.stopped", stopped, 1);     chk("stop.busy", busy, 0);
    chk("stop.pulse_cnt", pulse_cnt, m_completed);
    repeat (5) tick();
    chk("stop.pulse_cnt_hold", pulse_cnt, m_completed);
    chk("stop.no_done", m_done, 0);
    chk("stop.stopped_sticky", stopped, 1);
    run_vec(vecs[0]);

    // start and stop together while idle: stop wins, nothing starts.
    clear_mon();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    repeat (4) tick();
    chk("start_stop.busy_cycles", m_busy, 0);
    chk("start_stop.done", m_done, 0);
    chk("start_stop.stopped", stopped, 0);

    // Synchronous reset at a mid-pulse point on the second WL address.
    apply_cfg(vecs[1]);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 5000 && !reached; c++) begin
      tick();
      if (m_completed >= 16 && (set_mode | reset_mode) && m_k == 3) reached = 1'b1;
    end
    chk("rst_mid.reached_pulse", reached, 1);
    chk("rst_mid.wl_addr_before", wl_addr, 1);
    reset = 1'b1; tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    tick();
    chk("rst_mid.idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
